// File: rtl/rect_fill_ctrl.sv
// Rectangle fill sequencer: clips the requested box to the screen, then walks
// it row-major and strobes the VGA adapter's plot interface, stalling on hold.
module rect_fill_ctrl #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int C_W      = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [X_W-1:0] x0,
  input  logic [X_W-1:0] x1,
  input  logic [Y_W-1:0] y0,
  input  logic [Y_W-1:0] y1,
  input  logic [C_W-1:0] colour,
  input  logic           hold,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [C_W-1:0] vga_colour,
  output logic           vga_plot,
  output logic           busy,
  output logic           done
);

  // state | meaning
  // IDLE  | waiting for start; request fields latched on the accepting edge
  // SETUP | clip far corner to the screen, reject empty boxes, load counters
  // DRAW  | one pixel per un-held cycle, x fastest
  // DONE  | single-cycle completion pulse
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW, S_DONE} state_t;

  localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - 1);
  localparam logic [X_W-1:0] X_ONE = X_W'(1);
  localparam logic [Y_W-1:0] Y_ONE = Y_W'(1);

  state_t         state_q, state_d;
  logic [X_W-1:0] cx_q, cx_d, x0_q, x0_d, x1_q, x1_d;
  logic [Y_W-1:0] cy_q, cy_d, y0_q, y0_d, y1_q, y1_d;
  logic [C_W-1:0] colour_q, colour_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      cx_q     <= '0;
      cy_q     <= '0;
      x0_q     <= '0;
      x1_q     <= '0;
      y0_q     <= '0;
      y1_q     <= '0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      x0_q     <= x0_d;
      x1_q     <= x1_d;
      y0_q     <= y0_d;
      y1_q     <= y1_d;
      colour_q <= colour_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    x0_d     = x0_q;
    x1_d     = x1_q;
    y0_d     = y0_q;
    y1_d     = y1_q;
    colour_d = colour_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          x0_d     = x0;
          x1_d     = x1;
          y0_d     = y0;
          y1_d     = y1;
          colour_d = colour;
          state_d  = S_SETUP;
        end
      end
      S_SETUP: begin
        // Clipped bounds overwrite the raw ones so DRAW compares directly.
        x1_d = (x1_q > X_MAX) ? X_MAX : x1_q;
        y1_d = (y1_q > Y_MAX) ? Y_MAX : y1_q;
        if ((x0_q > x1_d) || (y0_q > y1_d)) begin
          state_d = S_DONE;
        end else begin
          cx_d    = x0_q;
          cy_d    = y0_q;
          state_d = S_DRAW;
        end
      end
      S_DRAW: begin
        if (!hold) begin
          if ((cx_q == x1_q) && (cy_q == y1_q)) begin
            state_d = S_DONE;
          end else if (cx_q == x1_q) begin
            cx_d = x0_q;
            cy_d = cy_q + Y_ONE;
          end else begin
            cx_d = cx_q + X_ONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign vga_x      = cx_q;
  assign vga_y      = cy_q;
  assign vga_colour = colour_q;
  assign vga_plot   = (state_q == S_DRAW) && !hold;
  assign busy       = (state_q == S_SETUP) || (state_q == S_DRAW);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_rect_fill_ctrl.sv
// Directed bench for rect_fill_ctrl: records every plot of each fill and
// compares order, count, timing and clipping against hand-computed values.
module tb_rect_fill_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] x0 = '0, x1 = '0;
  logic [6:0] y0 = '0, y1 = '0;
  logic [2:0] colour = '0;
  logic       hold = 1'b0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot, busy, done;

  int checks = 0;
  int failures = 0;

  logic [17:0] pq[$];
  int          pcyc[$];
  int          done_cyc;
  logic        busy_at_done;

  rect_fill_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .colour(colour), .hold(hold),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one request on the next edge, then log plots until done or timeout.
  // Cycle 1 is the cycle after the accepting edge.
  task automatic run_rect(input logic [7:0] ax0, input logic [7:0] ax1,
                          input logic [6:0] ay0, input logic [6:0] ay1,
                          input logic [2:0] col, input int hlen,
                          input int poke_cyc, input int limit);
    int cyc;
    int hold_cnt;
    bit hold_used;
    pq.delete();
    pcyc.delete();
    done_cyc = -1;
    busy_at_done = 1'bx;
    hold_cnt = 0;
    hold_used = 0;
    x0 = ax0; x1 = ax1; y0 = ay0; y1 = ay1; colour = col; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    x0 = 8'd77; x1 = 8'd1; y0 = 7'd55; y1 = 7'd2; colour = ~col;
    cyc = 1;
    while (cyc <= limit) begin
      hold = (hold_cnt > 0);
      if (hold_cnt > 0) hold_cnt--;
      start = (cyc == poke_cyc);
      if (cyc == poke_cyc) x0 = 8'd50;
      #1;
      if (vga_plot) begin
        pq.push_back({vga_x, vga_y, vga_colour});
        pcyc.push_back(cyc);
      end
      if (pq.size() == 2 && !hold_used && hlen > 0) begin
        hold_cnt = hlen;
        hold_used = 1;
      end
      if (done) begin
        done_cyc = cyc;
        busy_at_done = busy;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    hold = 1'b0;
    start = 1'b0;
  endtask

  // Count plots that deviate from a row-major walk over the given inclusive box.
  function automatic int order_mismatches(input int xa, input int xb, input int ya,
                                          input int yb, input logic [2:0] col);
    int idx = 0;
    int bad = 0;
    logic [17:0] e;
    for (int y = ya; y <= yb; y++)
      for (int x = xa; x <= xb; x++) begin
        e = {8'(x), 7'(y), col};
        if (idx >= pq.size() || pq[idx] !== e) bad++;
        idx++;
      end
    return bad;
  endfunction

  function automatic int consecutive_span();
    if (pcyc.size() == 0) return 0;
    return pcyc[pcyc.size()-1] - pcyc[0] + 1;
  endfunction

  initial begin
    int maxx, maxy;
    #3;
    chk("rst_plot", int'(vga_plot), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_xy", int'({vga_x, vga_y}), 0);
    chk("rst_colour", int'(vga_colour), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // 2x2 basic fill
    run_rect(8'd5, 8'd6, 7'd3, 7'd4, 3'd3, 0, 0, 100);
    chk("basic_count", pq.size(), 4);
    chk("basic_order", order_mismatches(5, 6, 3, 4, 3'd3), 0);
    chk("basic_first_cyc", pcyc.size() > 0 ? pcyc[0] : -1, 2);
    chk("basic_done_cyc", done_cyc, 6);
    chk("basic_busy_at_done", int'(busy_at_done), 0);
    @(posedge clk); #1;
    chk("basic_done_pulse", int'(done), 0);
    chk("basic_busy_after", int'(busy), 0);

    // full screen
    run_rect(8'd0, 8'd159, 7'd0, 7'd119, 3'd5, 0, 0, 20000);
    chk("full_count", pq.size(), 19200);
    chk("full_span", consecutive_span(), 19200);
    chk("full_last", pq.size() > 0 ? int'(pq[pq.size()-1]) : -1, int'({8'd159, 7'd119, 3'd5}));
    chk("full_order", order_mismatches(0, 159, 0, 119, 3'd5), 0);
    chk("full_done_cyc", done_cyc, 19202);
    @(posedge clk); #1;

    // clipped
    run_rect(8'd150, 8'd200, 7'd118, 7'd127, 3'd6, 0, 0, 200);
    chk("clip_count", pq.size(), 20);
    chk("clip_order", order_mismatches(150, 159, 118, 119, 3'd6), 0);
    maxx = 0; maxy = 0;
    foreach (pq[i]) begin
      if (int'(pq[i][17:10]) > maxx) maxx = int'(pq[i][17:10]);
      if (int'(pq[i][9:3]) > maxy) maxy = int'(pq[i][9:3]);
    end
    chk("clip_xmax", maxx, 159);
    chk("clip_ymax", maxy, 119);
    chk("clip_done_cyc", done_cyc, 22);
    @(posedge clk); #1;

    // empty boxes
    run_rect(8'd10, 8'd9, 7'd0, 7'd5, 3'd1, 0, 0, 50);
    chk("empty_count", pq.size(), 0);
    chk("empty_done_cyc", done_cyc, 2);
    @(posedge clk); #1;
    run_rect(8'd170, 8'd200, 7'd0, 7'd5, 3'd1, 0, 0, 50);
    chk("offscreen_count", pq.size(), 0);
    chk("offscreen_done_cyc", done_cyc, 2);
    @(posedge clk); #1;
    run_rect(8'd0, 8'd3, 7'd121, 7'd125, 3'd1, 0, 0, 50);
    chk("empty_y_count", pq.size(), 0);
    @(posedge clk); #1;

    // hold for 3 cycles after the 2nd plot
    run_rect(8'd20, 8'd21, 7'd10, 7'd11, 3'd2, 3, 0, 100);
    chk("hold_count", pq.size(), 4);
    chk("hold_order", order_mismatches(20, 21, 10, 11, 3'd2), 0);
    chk("hold_3rd_cyc", pcyc.size() > 2 ? pcyc[2] : -1, 7);
    chk("hold_done_cyc", done_cyc, 9);
    @(posedge clk); #1;

    // start pulsed mid-DRAW must not disturb the fill
    run_rect(8'd0, 8'd3, 7'd0, 7'd0, 3'd7, 0, 3, 100);
    chk("poke_count", pq.size(), 4);
    chk("poke_order", order_mismatches(0, 3, 0, 0, 3'd7), 0);
    chk("poke_done_cyc", done_cyc, 6);

    // start held through the edge leaving DONE is ignored; next edge accepts
    start = 1'b1; x0 = 8'd1; x1 = 8'd1; y0 = 7'd1; y1 = 7'd1;
    @(posedge clk); #1;
    chk("restart_ignored", int'(busy), 0);
    @(posedge clk); #1;
    chk("restart_accepted", int'(busy), 1);
    start = 1'b0;
    @(posedge clk); #1;
    chk("restart_plot", int'({vga_plot, vga_x, vga_y}), int'({1'b1, 8'd1, 7'd1}));
    @(posedge clk); #1;
    chk("restart_done", int'(done), 1);
    @(posedge clk); #1;

    // async reset mid-DRAW
    x0 = 8'd0; x1 = 8'd9; y0 = 7'd2; y1 = 7'd2; colour = 3'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    chk("pre_reset_plot", int'(vga_plot), 1);
    reset = 1'b0;
    #1;
    chk("mid_reset_plot", int'(vga_plot), 0);
    chk("mid_reset_busy", int'(busy), 0);
    chk("mid_reset_xy", int'({vga_x, vga_y}), 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_idle", int'(busy), 0);
    run_rect(8'd30, 8'd32, 7'd7, 7'd7, 3'd2, 0, 0, 100);
    chk("after_reset_count", pq.size(), 3);
    chk("after_reset_order", order_mismatches(30, 32, 7, 7, 3'd2), 0);
    chk("after_reset_done_cyc", done_cyc, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
